// File: rtl/sine_dds_gen_if.sv
// Control and sample-stream bundle for the DDS waveform generator.
// The master side is the generator; the slave side is the consumer and control source.
interface sine_dds_gen_if #(
  parameter int PHASE_W = 16,
  parameter int DATA_W  = 8
);
  logic               en;
  logic               sync_clr;
  logic [PHASE_W-1:0] ftw;
  logic [PHASE_W-1:0] phase_ofs;
  logic [1:0]         mode;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic               wrap;

  modport master (
    input  en, sync_clr, ftw, phase_ofs, mode, out_ready,
    output out_valid, out_data, wrap
  );

  modport slave (
    output en, sync_clr, ftw, phase_ofs, mode, out_ready,
    input  out_valid, out_data, wrap
  );
endinterface

// File: rtl/sine_dds_gen.sv
// DDS waveform generator: phase accumulator plus quarter-wave sine ROM, with square,
// triangle and sawtooth shapes, delivered as a valid/ready sample stream.
module sine_dds_gen #(
  parameter int PHASE_W = 16,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  sine_dds_gen_if.master    bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] POS_FS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_FS = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] HALF   = {1'b1, {(DATA_W-1){1'b0}}};

  // Entry i holds the sine at the centre of the i-th quarter-wave bin, rounded.
  function automatic logic [DATA_W-2:0] rom_entry(input int i);
    real amp;
    real ang;
    amp = real'((1 << (DATA_W-1)) - 1);
    ang = 3.14159265358979323846 * (real'(i) + 0.5) / real'(2 << ADDR_W);
    return (DATA_W-1)'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [DATA_W-2:0] rom [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
      localparam logic [DATA_W-2:0] ENTRY = rom_entry(gi);
      assign rom[gi] = ENTRY;
    end
  endgenerate

  logic [PHASE_W-1:0] acc_reg;
  logic [DATA_W-1:0]  data_reg;
  logic               valid_reg;
  logic               wrap_reg;

  logic               fire;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W:0]   acc_sum;
  logic [1:0]         quad;
  logic [ADDR_W-1:0]  idx;
  logic [DATA_W-2:0]  mag;
  logic [DATA_W-1:0]  tri_t;
  logic [DATA_W-1:0]  sample_next;
  logic               unused_phase_bits;

  assign fire    = bus.en && (!valid_reg || bus.out_ready) && !bus.sync_clr;
  assign phase   = acc_reg + bus.phase_ofs;
  assign acc_sum = {1'b0, acc_reg} + {1'b0, bus.ftw};

  assign quad  = phase[PHASE_W-1 -: 2];
  assign idx   = phase[PHASE_W-3 -: ADDR_W];
  // Odd quadrants read the table backwards to mirror the quarter wave.
  assign mag   = rom[quad[0] ? ~idx : idx];
  assign tri_t = phase[PHASE_W-2 -: DATA_W];

  // Phase bits below the lookup resolution are simply truncated.
  assign unused_phase_bits = ^phase;

  always_comb begin
    sample_next = '0;
    case (bus.mode)
      2'b00:   sample_next = quad[1] ? -{1'b0, mag} : {1'b0, mag};
      2'b01:   sample_next = phase[PHASE_W-1] ? NEG_FS : POS_FS;
      2'b10:   sample_next = phase[PHASE_W-1] ? (POS_FS - tri_t) : (tri_t - HALF);
      default: sample_next = {~phase[PHASE_W-1], phase[PHASE_W-2 -: DATA_W-1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      wrap_reg  <= 1'b0;
    end else if (bus.sync_clr) begin
      acc_reg   <= '0;
      valid_reg <= 1'b0;
      wrap_reg  <= 1'b0;
    end else if (fire) begin
      acc_reg   <= acc_sum[PHASE_W-1:0];
      wrap_reg  <= acc_sum[PHASE_W];
      data_reg  <= sample_next;
      valid_reg <= 1'b1;
    end else begin
      wrap_reg <= 1'b0;
      if (valid_reg && bus.out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_reg;
  assign bus.out_data  = data_reg;
  assign bus.wrap      = wrap_reg;
endmodule

// File: tb/tb_sine_dds_gen.sv
// Randomised and directed bench for sine_dds_gen: an arithmetic reference model feeds
// an expected-sample queue that an independent monitor drains on each handshake.
module tb_sine_dds_gen;
  localparam int PHASE_W = 16;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 8;
  localparam real PI     = 3.14159265358979323846;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sine_dds_gen_if #(.PHASE_W(PHASE_W), .DATA_W(DATA_W)) bus();

  sine_dds_gen #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int cap[$];
  int n_samples = 0;
  int m_acc = 0;
  bit m_valid = 1'b0;
  bit m_wrap  = 1'b0;

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Full-period sine sampled at 256 bin centres, plus the piecewise-linear shapes.
  function automatic int ref_sample(input int m, input int p);
    int  k;
    real v;
    case (m)
      0: begin
        k = p >> 8;
        v = 127.0 * $sin(2.0 * PI * (real'(k) + 0.5) / 256.0);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
      end
      1: return (p < 32768) ? 127 : -127;
      2: begin
        k = (p >> 7) & 255;
        return (p < 32768) ? (k - 128) : (127 - k);
      end
      default: return (p >> 8) - 128;
    endcase
  endfunction

  always @(negedge rst_n) begin
    m_acc   = 0;
    m_valid = 1'b0;
    m_wrap  = 1'b0;
    exp_q.delete();
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.sync_clr) begin
        if (m_valid && !bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        m_acc   = 0;
        m_valid = 1'b0;
        m_wrap  = 1'b0;
      end else if (bus.en && (!m_valid || bus.out_ready)) begin
        exp_q.push_back(ref_sample(int'(bus.mode), (m_acc + int'(bus.phase_ofs)) % 65536));
        m_valid = 1'b1;
        m_wrap  = (m_acc + int'(bus.ftw)) > 65535;
        m_acc   = (m_acc + int'(bus.ftw)) % 65536;
      end else begin
        m_wrap = 1'b0;
        if (m_valid && bus.out_ready) m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check_int("valid", int'(bus.out_valid), int'(m_valid));
    check_int("wrap", int'(bus.wrap), int'(m_wrap));
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_int("unexpected_sample", 1, 0);
      end else begin
        check_int("data", int'($signed(bus.out_data)), exp_q[0]);
        if (bus.out_ready) begin
          $display("sample %0d mode=%0d data=%0d exp=%0d", n_samples, bus.mode,
                   $signed(bus.out_data), exp_q[0]);
          n_samples++;
          cap.push_back(int'($signed(bus.out_data)));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic restart(input int m, input int f, input int o);
    bus.mode      = 2'(m);
    bus.ftw       = 16'(f);
    bus.phase_ofs = 16'(o);
    bus.en        = 1'b1;
    bus.out_ready = 1'b1;
    bus.sync_clr  = 1'b1;
    cyc(1);
    bus.sync_clr  = 1'b0;
    cap.delete();
  endtask

  int sq_tab [4] = '{127, 127, -127, -127};
  int saw_tab[4] = '{-128, -64, 0, 64};
  int tri_tab[4] = '{-128, 0, 127, -1};

  initial begin
    int bad;
    bus.en = 1'b0; bus.sync_clr = 1'b0; bus.ftw = '0; bus.phase_ofs = '0;
    bus.mode = 2'b00; bus.out_ready = 1'b0;
    cyc(3);
    check_int("rst_valid", int'(bus.out_valid), 0);
    check_int("rst_data", int'(bus.out_data), 0);
    check_int("rst_wrap", int'(bus.wrap), 0);
    rst_n = 1'b1;

    // Sine at 64 samples per period
    bus.ftw = 16'h0400; bus.en = 1'b1; bus.out_ready = 1'b1;
    cap.delete();
    cyc(130);
    check_int("s1_count_ok", int'(cap.size() >= 128), 1);
    if (cap.size() >= 128) begin
      check_int("s1_s0", cap[0], 2);
      check_int("s1_s16", cap[16], 127);
      check_int("s1_s32", cap[32], -2);
      check_int("s1_s48", cap[48], -127);
      bad = 0;
      for (int i = 0; i < 64; i++) if (cap[i + 64] != cap[i]) bad++;
      check_int("s1_period", bad, 0);
    end

    // Backpressure mid-stream
    cyc(5);
    bus.out_ready = 1'b0;
    cyc(3);
    bus.out_ready = 1'b1;
    cyc(6);

    // Square, sawtooth, triangle at quarter-period steps
    restart(1, 16'h4000, 0); cyc(5);
    check_int("s3_sq_n", int'(cap.size() >= 4), 1);
    if (cap.size() >= 4) for (int i = 0; i < 4; i++) check_int($sformatf("s3_sq%0d", i), cap[i], sq_tab[i]);
    restart(3, 16'h4000, 0); cyc(5);
    check_int("s3_saw_n", int'(cap.size() >= 4), 1);
    if (cap.size() >= 4) for (int i = 0; i < 4; i++) check_int($sformatf("s3_saw%0d", i), cap[i], saw_tab[i]);
    restart(2, 16'h4000, 0); cyc(5);
    check_int("s3_tri_n", int'(cap.size() >= 4), 1);
    if (cap.size() >= 4) for (int i = 0; i < 4; i++) check_int($sformatf("s3_tri%0d", i), cap[i], tri_tab[i]);

    // Cosine via phase offset
    restart(0, 16'h0400, 16'h4000); cyc(70);
    check_int("s4_n", int'(cap.size() >= 1), 1);
    if (cap.size() >= 1) check_int("s4_first", cap[0], 127);

    // sync_clr mid-stream, clear beats a pending fire
    restart(0, 16'h0400, 0); cyc(10);
    bus.sync_clr = 1'b1;
    cyc(1);
    check_int("s5_valid_clr", int'(bus.out_valid), 0);
    bus.sync_clr = 1'b0;
    cap.delete();
    cyc(3);
    check_int("s5_n", int'(cap.size() >= 1), 1);
    if (cap.size() >= 1) check_int("s5_first", cap[0], 2);

    // ftw = 0 holds a constant output
    restart(2, 0, 16'h1234); cyc(20);
    bad = 0;
    for (int i = 1; i < cap.size(); i++) if (cap[i] != cap[0]) bad++;
    check_int("ftw0_const", bad, 0);

    // Asynchronous reset between edges
    restart(0, 16'h0400, 0); cyc(7);
    #1 rst_n = 1'b0;
    #1;
    check_int("s6_valid", int'(bus.out_valid), 0);
    check_int("s6_data", int'(bus.out_data), 0);
    check_int("s6_wrap", int'(bus.wrap), 0);
    cyc(2);
    rst_n = 1'b1;
    cap.delete();
    cyc(3);
    check_int("s6_n", int'(cap.size() >= 1), 1);
    if (cap.size() >= 1) check_int("s6_first", cap[0], 2);
    bus.en = 1'b0;
    cyc(3);
    check_int("s6_drain", int'(bus.out_valid), 0);
    bus.en = 1'b1;
    cyc(5);

    // Randomised traffic
    repeat (3000) begin
      bus.en        = ($urandom_range(0, 9) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.sync_clr  = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 9) == 0) begin
        bus.mode      = 2'($urandom_range(0, 3));
        bus.ftw       = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 2047));
        bus.phase_ofs = 16'($urandom);
      end
      cyc(1);
    end
    bus.sync_clr = 1'b0;
    bus.en = 1'b0;
    bus.out_ready = 1'b1;
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
